// File: rtl/dma_csr_launcher.sv
// rtl/dma_csr_launcher.sv - AXI4-Lite master that programs one DMA descriptor, launches it,
// waits for the DMA interrupt and returns the DMA Status word as a one-beat result.
module dma_csr_launcher #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_src_addr,
    input  logic [DATA_WIDTH-1:0] req_dst_addr,
    input  logic [DATA_WIDTH-1:0] req_num_bytes,
    input  logic [DATA_WIDTH-1:0] req_cfg,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_status,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    input  logic                  dma_done_i,
    input  logic                  dma_error_i,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, WR_AW, WR_B, WAIT_IRQ, RD_AR, RD_R, RESP
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] src_q, src_d, dst_q, dst_d, nb_q, nb_d, cfg_q, cfg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  req_ready_d, rsp_valid_d, rsp_error_d, rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_status_d, wdata_d;
    logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
    logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    // Descriptor register map: src, dst, length, config, then the control/start register.
    function automatic logic [ADDR_WIDTH-1:0] csr_addr(input logic [2:0] i);
        case (i)
            3'd0:    csr_addr = ADDR_WIDTH'(8'h20);
            3'd1:    csr_addr = ADDR_WIDTH'(8'h30);
            3'd2:    csr_addr = ADDR_WIDTH'(8'h40);
            3'd3:    csr_addr = ADDR_WIDTH'(8'h50);
            default: csr_addr = '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] csr_data(
        input logic [2:0]            i,
        input logic [DATA_WIDTH-1:0] s,
        input logic [DATA_WIDTH-1:0] d,
        input logic [DATA_WIDTH-1:0] n,
        input logic [DATA_WIDTH-1:0] c
    );
        case (i)
            3'd0:    csr_data = s;
            3'd1:    csr_data = d;
            3'd2:    csr_data = n;
            3'd3:    csr_data = c;
            default: csr_data = DATA_WIDTH'(1);
        endcase
    endfunction

    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;
    assign m_wstrb  = 4'hF;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        src_d         = src_q;
        dst_d         = dst_q;
        nb_d          = nb_q;
        cfg_d         = cfg_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid;
        rsp_status_d  = rsp_status;
        rsp_error_d   = rsp_error;
        rsp_timeout_d = rsp_timeout;
        awaddr_d      = m_awaddr;
        wdata_d       = m_wdata;
        awvalid_d     = m_awvalid;
        wvalid_d      = m_wvalid;
        bready_d      = m_bready;
        araddr_d      = m_araddr;
        arvalid_d     = m_arvalid;
        rready_d      = m_rready;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    src_d = req_src_addr;
                    dst_d = req_dst_addr;
                    nb_d  = req_num_bytes;
                    cfg_d = req_cfg;
                    idx_d = 3'd0;
                    if (req_num_bytes == '0) begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_error_d  = 1'b1;
                        rsp_status_d = '0;
                    end else begin
                        state_d   = WR_AW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = csr_addr(3'd0);
                        wdata_d   = csr_data(3'd0, req_src_addr, req_dst_addr, req_num_bytes, req_cfg);
                    end
                end
            end
            WR_AW: begin
                if (m_awvalid && m_awready) awvalid_d = 1'b0;
                if (m_wvalid && m_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end
            WR_B: begin
                if (m_bvalid && m_bready) begin
                    bready_d = 1'b0;
                    if (m_bresp != 2'b00) begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_error_d  = 1'b1;
                        rsp_status_d = '0;
                    end else if (idx_q == 3'd4) begin
                        state_d = WAIT_IRQ;
                        idx_d   = 3'd5;
                        cnt_d   = '0;
                    end else begin
                        state_d   = WR_AW;
                        idx_d     = idx_q + 3'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = csr_addr(idx_q + 3'd1);
                        wdata_d   = csr_data(idx_q + 3'd1, src_q, dst_q, nb_q, cfg_q);
                    end
                end
            end
            WAIT_IRQ: begin
                // Error is checked first so a simultaneous done/error reports as an error.
                if (dma_error_i || dma_done_i ||
                    (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST)) begin
                    state_d   = RD_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = ADDR_WIDTH'(8'h08);
                    if (dma_error_i)
                        rsp_error_d = 1'b1;
                    else if (!dma_done_i)
                        rsp_timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_AR: begin
                if (m_arready) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_R: begin
                if (m_rvalid) begin
                    state_d      = RESP;
                    rready_d     = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = m_rdata;
                    if (m_rresp != 2'b00) rsp_error_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_error_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_status_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            nb_q        <= '0;
            cfg_q       <= '0;
            cnt_q       <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            m_awaddr    <= '0;
            m_wdata     <= '0;
            m_awvalid   <= 1'b0;
            m_wvalid    <= 1'b0;
            m_bready    <= 1'b0;
            m_araddr    <= '0;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            nb_q        <= nb_d;
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_status  <= rsp_status_d;
            rsp_error   <= rsp_error_d;
            rsp_timeout <= rsp_timeout_d;
            m_awaddr    <= awaddr_d;
            m_wdata     <= wdata_d;
            m_awvalid   <= awvalid_d;
            m_wvalid    <= wvalid_d;
            m_bready    <= bready_d;
            m_araddr    <= araddr_d;
            m_arvalid   <= arvalid_d;
            m_rready    <= rready_d;
        end
    end

endmodule

// File: tb/tb_dma_csr_launcher.sv
// tb/tb_dma_csr_launcher.sv - table-driven, randomized and corner-case checks for dma_csr_launcher
module tb_dma_csr_launcher;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [31:0] req_src_addr, req_dst_addr, req_num_bytes, req_cfg, rsp_status;
    logic        dma_done_i, dma_error_i;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    always #5 clk = ~clk;

    dma_csr_launcher #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
        .req_num_bytes(req_num_bytes), .req_cfg(req_cfg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave behaviour knobs and observation logs
    int          aw_delay, w_delay, berr_idx, irq_mode, irq_delay;
    logic [31:0] rd_value;
    logic [1:0]  rd_resp;
    logic [31:0] aw_log[$], w_log[$];
    int          b_cnt, wait_cnt, rd_cnt, rd_bad_addr, axi_viol, entry_cyc, ar_cyc;
    int          aw_wait, w_wait;
    logic        b_fire, ar_fire, r_fire, rd_pend, p_aw_hold, p_w_hold;
    logic [31:0] p_awaddr, p_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI4-Lite slave plus interrupt source; all slave decisions happen on the falling edge.
    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_arready = 0;
        m_rvalid = 0; m_rdata = 0; m_rresp = 0; dma_done_i = 0; dma_error_i = 0;
        b_fire = 0; ar_fire = 0; r_fire = 0; rd_pend = 0; p_aw_hold = 0; p_w_hold = 0;
        aw_wait = 0; w_wait = 0; p_awaddr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                dma_done_i = 0; dma_error_i = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                rd_pend = 0; p_aw_hold = 0; p_w_hold = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (p_aw_hold && (!m_awvalid || m_awaddr != p_awaddr)) axi_viol++;
                if (p_w_hold && (!m_wvalid || m_wdata != p_wdata)) axi_viol++;
                if (b_fire) begin m_bvalid = 0; b_cnt++; end
                if (ar_fire) rd_pend = 1;
                if (r_fire) m_rvalid = 0;
                dma_done_i = 0;
                dma_error_i = 0;
                if (b_cnt == 5) begin
                    if (wait_cnt == 0) entry_cyc = cyc;
                    if (wait_cnt >= irq_delay) begin
                        dma_done_i  = irq_mode[0];
                        dma_error_i = irq_mode[1];
                    end
                    wait_cnt++;
                end
                if (!m_bvalid && aw_log.size() > b_cnt && w_log.size() > b_cnt) begin
                    m_bvalid = 1;
                    m_bresp  = (b_cnt == berr_idx) ? 2'b10 : 2'b00;
                end
                m_awready = m_awvalid && (aw_wait >= aw_delay);
                if (m_awvalid && m_awready) begin aw_log.push_back(m_awaddr); aw_wait = 0; end
                else if (m_awvalid) aw_wait++;
                m_wready = m_wvalid && (w_wait >= w_delay);
                if (m_wvalid && m_wready) begin w_log.push_back(m_wdata); w_wait = 0; end
                else if (m_wvalid) w_wait++;
                m_arready = m_arvalid;
                ar_fire   = m_arvalid;
                if (m_arvalid) begin
                    if (rd_cnt == 0) ar_cyc = cyc;
                    if (m_araddr != 32'h8) rd_bad_addr++;
                    rd_cnt++;
                end
                if (rd_pend && !m_rvalid) begin
                    m_rvalid = 1; m_rdata = rd_value; m_rresp = rd_resp; rd_pend = 0;
                end
                r_fire    = m_rvalid && m_rready;
                b_fire    = m_bvalid && m_bready;
                p_aw_hold = m_awvalid && !m_awready;
                p_awaddr  = m_awaddr;
                p_w_hold  = m_wvalid && !m_wready;
                p_wdata   = m_wdata;
            end
        end
    end

    typedef struct {
        logic [31:0] src, dst, nbytes, cfg;
        int          aw_dly, w_dly, berr, irq_mode, irq_dly;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] exp_status;
        logic        exp_error, exp_timeout;
        int          exp_writes, exp_reads;
    } vec_t;

    // Reference outcome of one launch, derived from the register-sequence rules.
    function automatic void model(input vec_t v, output logic [31:0] st, output logic er,
                                  output logic to, output int nw, output int nr, output int lat);
        logic seen;
        st = 0; er = 0; to = 0; nw = 0; nr = 0; lat = 0;
        if (v.nbytes == 0) begin
            er = 1;
        end else if (v.berr >= 0 && v.berr < 5) begin
            er = 1; nw = v.berr + 1;
        end else begin
            seen = (v.irq_mode != 0) && (v.irq_dly < TO);
            nw = 5; nr = 1; st = v.rdata; to = !seen;
            er  = (seen && v.irq_mode >= 2) || (v.rresp != 2'b00);
            lat = seen ? v.irq_dly + 1 : TO;
        end
    endfunction

    function automatic logic [63:0] exp_pair(input vec_t v, input int i);
        logic [31:0] a[5];
        logic [31:0] d[5];
        a = '{32'h20, 32'h30, 32'h40, 32'h50, 32'h00};
        d = '{v.src, v.dst, v.nbytes, v.cfg, 32'h1};
        return {a[i], d[i]};
    endfunction

    task automatic clear_slave(input vec_t v);
        aw_log.delete(); w_log.delete();
        b_cnt = 0; wait_cnt = 0; rd_cnt = 0; rd_bad_addr = 0; axi_viol = 0;
        entry_cyc = -1; ar_cyc = -1;
        aw_delay = v.aw_dly; w_delay = v.w_dly; berr_idx = v.berr;
        irq_mode = v.irq_mode; irq_delay = v.irq_dly; rd_value = v.rdata; rd_resp = v.rresp;
    endtask

    task automatic send_req(input vec_t v, output int t_acc, output logic ok);
        int n = 0;
        req_valid = 1; req_src_addr = v.src; req_dst_addr = v.dst;
        req_num_bytes = v.nbytes; req_cfg = v.cfg;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        ok = req_ready;
        t_acc = cyc;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic run_and_check(input vec_t v, input logic [31:0] e_st, input logic e_er,
                                 input logic e_to, input int e_nw, input int e_nr);
        int t_acc, n, hold, lat, nw_m, nr_m;
        logic ok, bad, wr_ok, er_m, to_m;
        logic [31:0] st, st_m;
        logic er, to;
        model(v, st_m, er_m, to_m, nw_m, nr_m, lat);
        @(posedge clk); #1;
        clear_slave(v);
        send_req(v, t_acc, ok);
        chk("req_accept", ok, 1);
        if (!ok) return;
        if (v.nbytes == 0) chk("zero_len_rsp_latency", {req_ready, rsp_valid, m_awvalid}, 3'b010);
        else chk("launch_latency", {req_ready, m_awvalid, m_wvalid}, 3'b011);
        n = 0;
        while (!rsp_valid && n < 400) begin @(posedge clk); #1; n++; end
        chk("rsp_arrives", rsp_valid, 1);
        if (!rsp_valid) return;
        st = rsp_status; er = rsp_error; to = rsp_timeout;
        hold = $urandom_range(0, 2);
        bad = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_status != st || rsp_error != er || rsp_timeout != to) bad = 1;
        end
        chk("rsp_held_stable", bad, 0);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("rsp_cleared", {rsp_valid, rsp_error, rsp_timeout}, 3'b000);
        chk("rsp_status", st, e_st);
        chk("rsp_error", er, e_er);
        chk("rsp_timeout", to, e_to);
        chk("write_count", {aw_log.size(), w_log.size()}, {e_nw, e_nw});
        wr_ok = 1;
        for (int i = 0; i < aw_log.size() && i < w_log.size() && i < 5; i++)
            if ({aw_log[i], w_log[i]} != exp_pair(v, i)) wr_ok = 0;
        chk("write_sequence", wr_ok, 1);
        chk("read_count", rd_cnt, e_nr);
        chk("read_addr_and_axi_hold", {rd_bad_addr, axi_viol}, 64'd0);
        if (e_nr == 1) chk("irq_to_read_latency", ar_cyc - entry_cyc, lat);
        if (e_nr == 1 && v.aw_dly == 0 && v.w_dly == 0)
            chk("wait_irq_entry_latency", entry_cyc - t_acc, 11);
    endtask

    vec_t tbl[14];
    vec_t rv, nom;

    initial begin
        logic [31:0] m_st;
        logic m_er, m_to;
        int m_nw, m_nr, m_lat, t_acc, n;
        logic ok;

        tbl[0]  = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 0, 0, -1, 1, 0,  32'h1,  2'b00, 32'h1,  0, 0, 5, 1};
        tbl[1]  = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 3, 0, -1, 1, 2,  32'h5,  2'b00, 32'h5,  0, 0, 5, 1};
        tbl[2]  = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 0, 0, 2,  1, 0,  32'h1,  2'b00, 32'h0,  1, 0, 3, 0};
        tbl[3]  = '{32'hA000_0040, 32'hB000_0080, 32'h100, 32'h3, 0, 0, -1, 3, 1,  32'h3,  2'b00, 32'h3,  1, 0, 5, 1};
        tbl[4]  = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 0, 0, -1, 0, 0,  32'h10, 2'b00, 32'h10, 0, 1, 5, 1};
        tbl[5]  = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0,   32'h1, 0, 0, -1, 1, 0,  32'h1,  2'b00, 32'h0,  1, 0, 0, 0};
        tbl[6]  = '{32'h0000_1000, 32'h0000_2000, 32'h20,  32'h0, 0, 0, -1, 2, 4,  32'h2,  2'b00, 32'h2,  1, 0, 5, 1};
        tbl[7]  = '{32'h0000_1000, 32'h0000_2000, 32'h20,  32'h0, 0, 0, -1, 1, 0,  32'hAB, 2'b10, 32'hAB, 1, 0, 5, 1};
        tbl[8]  = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 0, 0, -1, 1, 15, 32'h1,  2'b00, 32'h1,  0, 0, 5, 1};
        tbl[9]  = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 0, 0, -1, 1, 16, 32'h1,  2'b00, 32'h1,  0, 1, 5, 1};
        tbl[10] = '{32'hFFFF_FFF0, 32'h0000_0010, 32'h8,   32'h5, 0, 2, -1, 1, 3,  32'h9,  2'b00, 32'h9,  0, 0, 5, 1};
        tbl[11] = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 1, 1, 0,  1, 0,  32'h1,  2'b00, 32'h0,  1, 0, 1, 0};
        tbl[12] = '{32'h1000_0000, 32'h2000_0000, 32'h400, 32'h7, 0, 0, 4,  1, 0,  32'h1,  2'b00, 32'h0,  1, 0, 5, 0};
        tbl[13] = '{32'h5555_0000, 32'h6666_0000, 32'h1,   32'hF, 2, 3, -1, 3, 0,  32'h7,  2'b00, 32'h7,  1, 0, 5, 1};
        nom = tbl[0];

        req_valid = 0; rsp_ready = 0; req_src_addr = 0; req_dst_addr = 0;
        req_num_bytes = 0; req_cfg = 0;
        clear_slave(nom);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {req_ready, rsp_valid, rsp_error, rsp_timeout, m_awvalid,
                           m_wvalid, m_bready, m_arvalid, m_rready}, 9'd0);
        chk("reset_data", {m_awaddr, m_wdata, m_araddr, rsp_status}, 128'd0);
        rst = 1;
        @(posedge clk); #1;
        chk("idle_req_ready", req_ready, 1);

        for (int i = 0; i < 14; i++)
            run_and_check(tbl[i], tbl[i].exp_status, tbl[i].exp_error, tbl[i].exp_timeout,
                          tbl[i].exp_writes, tbl[i].exp_reads);

        // Reset while a write response is outstanding, then a clean full launch.
        @(posedge clk); #1;
        clear_slave(nom);
        send_req(nom, t_acc, ok);
        chk("reset_test_accept", ok, 1);
        n = 0;
        while (!m_bready && n < 50) begin @(posedge clk); #1; n++; end
        chk("reset_test_in_wr_b", m_bready, 1);
        rst = 0;
        #1;
        chk("midop_reset_ctrl", {req_ready, rsp_valid, rsp_error, rsp_timeout, m_awvalid,
                                 m_wvalid, m_bready, m_arvalid, m_rready}, 9'd0);
        chk("midop_reset_data", {m_awaddr, m_wdata, m_araddr, rsp_status}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        run_and_check(nom, 32'h1, 0, 0, 5, 1);

        for (int k = 0; k < 40; k++) begin
            rv.src      = $urandom;
            rv.dst      = $urandom;
            rv.nbytes   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            rv.cfg      = $urandom;
            rv.aw_dly   = $urandom_range(0, 3);
            rv.w_dly    = $urandom_range(0, 3);
            rv.berr     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
            rv.irq_mode = $urandom_range(0, 3);
            rv.irq_dly  = $urandom_range(0, 20);
            rv.rdata    = $urandom;
            rv.rresp    = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
            model(rv, m_st, m_er, m_to, m_nw, m_nr, m_lat);
            run_and_check(rv, m_st, m_er, m_to, m_nw, m_nr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
